// File: rtl/jpeg_rd_pkg.sv
// Shared types and address map for the JPEG result reader.
package jpeg_rd_pkg;

    typedef enum logic [2:0] {IDLE, POLL, READ, CLEAR, DRAIN} rd_state_t;

    localparam logic [31:0] OUTMEM_OFS  = 32'h0000_0800;
    localparam logic [31:0] CSR_OFS     = 32'h0000_1000;
    localparam int          BLOCK_WORDS = 32;

endpackage

// File: rtl/jpeg_rd_fifo.sv
// Synchronous word FIFO with combinational head and a flush that empties it in one cycle.
module jpeg_rd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rptr];
    assign count  = r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/jpeg_result_reader.sv
// Wishbone master: polls the accelerator CSR, reads the 32-word result block into a FIFO,
// streams it as 64 coefficients, then writes 0 to the CSR to release the block.
module jpeg_result_reader
    import jpeg_rd_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h9600_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          RDY_BIT    = 7
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [15:0] coef_o,
    output logic        coef_valid_o,
    input  logic        coef_ready_i,
    output logic        coef_last_o,
    output logic [2:0]  dbg_state_o
);
    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    rd_state_t    r_state;
    logic [4:0]   r_wcnt;
    logic [4:0]   r_ocnt;
    logic         r_half;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic         r_stb;
    logic         r_we;
    logic [31:0]  r_adr;

    logic          w_ack;
    logic          w_bus_err;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_dout;
    logic [CW-1:0] w_count;
    logic          w_unused_dat;

    // Valid/ready: a coefficient transfers on a clock edge where coef_valid_o & coef_ready_i;
    // until then coef_o/coef_last_o are held because they depend only on the FIFO head and r_half.
    assign w_bus_err    = r_stb & wbm_err_i;
    assign w_ack        = r_stb & wbm_ack_i & ~wbm_err_i;
    assign w_hs         = coef_valid_o & coef_ready_i;
    assign w_push       = (r_state == READ) & w_ack;
    assign w_pop        = w_hs & r_half;
    assign w_unused_dat = ^wbm_dat_i;

    jpeg_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush   (w_bus_err),
        .push    (w_push),
        .pop     (w_pop),
        .din     (wbm_dat_i),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign coef_valid_o = ~w_empty;
    assign coef_o       = coef_valid_o ? (r_half ? w_dout[15:0] : w_dout[31:16]) : 16'h0;
    assign coef_last_o  = coef_valid_o & r_half & (r_ocnt == 5'(BLOCK_WORDS - 1));

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = 32'h0;
    assign wbm_we_o    = r_we;
    assign wbm_sel_o   = {4{r_stb}};
    assign wbm_cyc_o   = r_stb;
    assign wbm_stb_o   = r_stb;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_half <= 1'b0;
            r_ocnt <= '0;
        end else if (w_bus_err) begin
            r_half <= 1'b0;
            r_ocnt <= '0;
        end else if (w_hs) begin
            r_half <= ~r_half;
            if (r_half) r_ocnt <= r_ocnt + 1'b1;
        end
    end

    // A read is only issued with no transfer in flight and a free FIFO slot, so every
    // returning word already owns the slot it is pushed into.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_bus_err) begin
                r_stb   <= 1'b0;
                r_we    <= 1'b0;
                r_wcnt  <= '0;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_i && !r_done) begin
                            r_busy  <= 1'b1;
                            r_state <= POLL;
                        end
                    end
                    POLL: begin
                        if (!r_stb) begin
                            r_stb <= 1'b1;
                            r_we  <= 1'b0;
                            r_adr <= BASE_ADR + CSR_OFS;
                        end else if (w_ack) begin
                            r_stb <= 1'b0;
                            if (wbm_dat_i[RDY_BIT]) r_state <= READ;
                        end
                    end
                    READ: begin
                        if (!r_stb) begin
                            if (w_count < DEPTH_C) begin
                                r_stb <= 1'b1;
                                r_adr <= BASE_ADR + OUTMEM_OFS + {25'd0, r_wcnt, 2'b00};
                            end
                        end else if (w_ack) begin
                            r_stb  <= 1'b0;
                            r_wcnt <= r_wcnt + 1'b1;
                            if (r_wcnt == 5'(BLOCK_WORDS - 1)) r_state <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (!r_stb) begin
                            r_stb <= 1'b1;
                            r_we  <= 1'b1;
                            r_adr <= BASE_ADR + CSR_OFS;
                        end else if (w_ack) begin
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (w_empty) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jpeg_result_reader.sv
// Bench for jpeg_result_reader: Wishbone slave model, coefficient sink and block-level scoreboard.
`timescale 1ns/1ps
module tb_jpeg_result_reader;
  import jpeg_rd_pkg::*;

  localparam logic [31:0] BASE  = 32'h9600_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_o;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        we, cyc, stb;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic        err_i = 1'b0;
  logic [15:0] coef;
  logic        cvalid, clast;
  logic        cready = 1'b0;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  jpeg_result_reader #(.BASE_ADR(BASE), .FIFO_DEPTH(DEPTH), .RDY_BIT(7)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err_o),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_ack_i(ack), .wbm_err_i(err_i),
    .coef_o(coef), .coef_valid_o(cvalid), .coef_ready_i(cready), .coef_last_o(clast),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] mem [32];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          got_last_q[$];
  int csr_not_ready, err_word, lat_max, ready_mode;
  int n_csr_rd, n_csr_wr, n_mem_rd, n_wr_bad, n_order_bad, n_unstable_adr, n_err_cyc_bad;
  int n_unstable, n_done, n_errp, exp_word;
  int first_ack_cyc, first_valid_cyc;
  int cyc_cnt = 0;
  bit ready_seen;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- Wishbone slave model ----------------
  int          lat;
  int          w;
  bit          prev_stb = 1'b0;
  bit          err_pend = 1'b0;
  logic [31:0] cur_adr;

  always @(negedge clk) begin
    ack = 1'b0; err_i = 1'b0; dat_i = 32'h0;
    if (err_pend) begin
      if (cyc || stb) n_err_cyc_bad++;
      err_pend = 1'b0;
    end
    if (!rst_n) prev_stb = 1'b0;
    else if (stb) begin
      if (!prev_stb) begin lat = $urandom_range(0, lat_max); cur_adr = adr; end
      else if (adr !== cur_adr) n_unstable_adr++;
      prev_stb = 1'b1;
      if (lat > 0) lat--;
      else if (we) begin
        n_csr_wr++;
        if (adr !== BASE + CSR_OFS || dat_o !== 32'h0 || sel !== 4'hF || !cyc) n_wr_bad++;
        ack = 1'b1;
      end else if (adr == BASE + CSR_OFS) begin
        n_csr_rd++;
        if (csr_not_ready > 0) begin csr_not_ready--; dat_i = 32'h0; end
        else begin dat_i = 32'h80; ready_seen = 1'b1; end
        ack = 1'b1;
      end else if (adr >= BASE + OUTMEM_OFS && adr < BASE + OUTMEM_OFS + 32'd128) begin
        w = int'((adr - BASE - OUTMEM_OFS) >> 2);
        if (!ready_seen || w != exp_word || sel !== 4'hF || !cyc) n_order_bad++;
        if (w == err_word) begin err_i = 1'b1; err_pend = 1'b1; end
        else begin
          dat_i = mem[w]; ack = 1'b1; n_mem_rd++; exp_word++;
          if (first_ack_cyc < 0) first_ack_cyc = cyc_cnt;
        end
      end else begin
        n_order_bad++; ack = 1'b1;
      end
    end else prev_stb = 1'b0;
  end

  // ---------------- coefficient sink ----------------
  bit          hold = 1'b0;
  logic [15:0] hold_coef;
  logic        hold_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      cready = 1'b0; hold = 1'b0;
    end else begin
      if (hold && (!cvalid || coef !== hold_coef || clast !== hold_last)) n_unstable++;
      case (ready_mode)
        0: cready = 1'b1;
        1: cready = 1'($urandom_range(0, 1));
        2: cready = 1'b0;
        default: cready = (got_q.size() == 0);
      endcase
      if (cvalid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
      if (cvalid && cready) begin got_q.push_back(coef); got_last_q.push_back(clast); end
      hold = cvalid && !cready; hold_coef = coef; hold_last = clast;
      if (done) n_done++;
      if (err_o) n_errp++;
    end
  end

  // ---------------- driver / scoreboard tasks ----------------
  task automatic prepare(input int pat, input int polls, input int ew, input int lm, input int rm);
    for (int k = 0; k < 32; k++) mem[k] = (pat != 0) ? {16'(2*k), 16'(2*k+1)} : $urandom;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin exp_q.push_back(mem[k][31:16]); exp_q.push_back(mem[k][15:0]); end
    got_q.delete(); got_last_q.delete();
    n_csr_rd = 0; n_csr_wr = 0; n_mem_rd = 0; n_wr_bad = 0; n_order_bad = 0;
    n_unstable_adr = 0; n_err_cyc_bad = 0; n_unstable = 0; n_done = 0; n_errp = 0;
    exp_word = 0; ready_seen = 1'b0; csr_not_ready = polls; err_word = ew;
    lat_max = lm; ready_mode = rm; first_ack_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic run_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    check({name, "_timeout"}, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero(input string p);
    check({p, "_busy"}, busy, 0);      check({p, "_done"}, done, 0);
    check({p, "_err"}, err_o, 0);      check({p, "_cyc"}, cyc, 0);
    check({p, "_stb"}, stb, 0);        check({p, "_we"}, we, 0);
    check({p, "_sel"}, sel, 0);        check({p, "_adr"}, adr, 0);
    check({p, "_dat"}, dat_o, 0);      check({p, "_coef"}, coef, 0);
    check({p, "_valid"}, cvalid, 0);   check({p, "_last"}, clast, 0);
  endtask

  task automatic compare_stream(input string p, input int n_exp, input bit prefix);
    int bad = 0, nl = 0, lastpos = -1;
    if (prefix) check({p, "_coef_count_le"}, longint'(got_q.size() <= n_exp), 1);
    else        check({p, "_coef_count"}, got_q.size(), n_exp);
    for (int i = 0; i < got_q.size(); i++) begin
      if (i >= exp_q.size() || got_q[i] !== exp_q[i]) bad++;
      if (got_last_q[i]) begin nl++; lastpos = i; end
    end
    check({p, "_coef_seq_bad"}, bad, 0);
    check({p, "_last_count"}, nl, prefix ? 0 : 1);
    if (!prefix) check({p, "_last_pos"}, lastpos, 63);
    check({p, "_hold_unstable"}, n_unstable, 0);
  endtask

  task automatic check_bus(input string p);
    check({p, "_rd_order_bad"}, n_order_bad, 0);
    check({p, "_wr_bad"}, n_wr_bad, 0);
    check({p, "_adr_unstable"}, n_unstable_adr, 0);
    check({p, "_cyc_after_err"}, n_err_cyc_bad, 0);
    check({p, "_fifo_empty"}, cvalid, 0);
    check({p, "_state_idle"}, dbg_state, 3'(IDLE));
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    int pat; int polls; int rmode; int lat; int err_word;
    int exp_csr_rd; int exp_csr_wr; int exp_mem_rd; int exp_coefs; int exp_done; int exp_err;
  } vec_t;
  vec_t vecs[5];
  vec_t v;

  initial begin : main
    int n;
    int c;
    vecs[0] = '{1, 2, 0, 0, -1, 3, 1, 32, 64, 1, 0};
    vecs[1] = '{0, 0, 1, 2, -1, 1, 1, 32, 64, 1, 0};
    vecs[2] = '{0, 5, 1, 1, -1, 6, 1, 32, 64, 1, 0};
    vecs[3] = '{0, 0, 0, 1, 10, 1, 0, 10, 20, 0, 1};
    vecs[4] = '{0, 1, 1, 2, 0, 2, 0, 0, 0, 0, 1};
    prepare(0, 0, -1, 0, 0);

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      prepare(v.pat, v.polls, v.err_word, v.lat, v.rmode);
      run_start();
      check($sformatf("v%0d_busy_after_start", i), busy, 1);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_csr_reads", i), n_csr_rd, v.exp_csr_rd);
      check($sformatf("v%0d_csr_writes", i), n_csr_wr, v.exp_csr_wr);
      check($sformatf("v%0d_mem_reads", i), n_mem_rd, v.exp_mem_rd);
      check($sformatf("v%0d_done_pulses", i), n_done, v.exp_done);
      check($sformatf("v%0d_err_pulses", i), n_errp, v.exp_err);
      compare_stream($sformatf("v%0d", i), v.exp_coefs, v.err_word >= 0);
      check_bus($sformatf("v%0d", i));
      if (v.err_word != 0)
        check($sformatf("v%0d_first_coef_latency", i),
              longint'(first_valid_cyc - first_ack_cyc >= 1 && first_valid_cyc - first_ack_cyc <= 2), 1);
    end

    // Backpressure: one coefficient accepted, then the sink stalls for 40 cycles.
    prepare(0, 0, -1, 0, 3);
    run_start();
    n = 0;
    while (got_q.size() == 0 && n < 500) begin @(negedge clk); n++; end
    check("bp_first_coef_seen", got_q.size(), 1);
    repeat (40) @(negedge clk);
    check("bp_reads_during_stall", n_mem_rd, DEPTH);
    check("bp_accepted_during_stall", got_q.size(), 1);
    ready_mode = 0;
    wait_idle("bp");
    compare_stream("bp", 64, 1'b0);
    check_bus("bp");

    // start_i coinciding with done_o must not begin another block.
    prepare(0, 1, -1, 0, 0);
    run_start();
    n = 0;
    while (!done && n < 4000) begin @(negedge clk); n++; end
    check("sd_done_seen", done, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = n_csr_rd;
    repeat (6) @(negedge clk);
    check("sd_start_ignored_busy", busy, 0);
    check("sd_start_ignored_polls", n_csr_rd, c);
    compare_stream("sd", 64, 1'b0);

    // Asynchronous reset in the middle of the read phase.
    prepare(0, 0, -1, 1, 1);
    run_start();
    n = 0;
    while (n_mem_rd < 20 && n < 2000) begin @(negedge clk); n++; end
    check("rst_mid_reached_word20", longint'(n_mem_rd >= 20), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    prepare(1, 0, -1, 1, 0);
    run_start();
    wait_idle("after_rst");
    check("after_rst_mem_reads", n_mem_rd, 32);
    check("after_rst_done", n_done, 1);
    compare_stream("after_rst", 64, 1'b0);
    check_bus("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
